data_cache: RTL and testbench
=============================

DATA_CACHE -- requirements
Module: data_cache

Interface
REQ-001 The block SHALL expose parameter LINES, default 16, meaning the number of direct-mapped one-word lines (power of 2, 4..256).
REQ-002 The block SHALL expose parameter IDXW, default 4, meaning log2(LINES).
REQ-003 clk_i  in  1  the single clock; all state changes on its rising edge.
REQ-004 rst_i  in  1  reset, synchronous and active-high.
REQ-005 cpu_rd_i  in  1  load request from the pipeline MEM stage.
REQ-006 cpu_wr_i  in  1  store request.
REQ-007 cpu_addr_i  in  32  byte address; bits [1:0] are ignored.
REQ-008 cpu_wdata_i  in  32  store data.
REQ-009 cpu_rdata_o  out  32  load data, valid when cpu_rd_i=1 and cpu_stall_o=0.
REQ-010 cpu_stall_o  out  1  access not complete; the CPU holds the request stable while this is high.
REQ-011 mem_req_o, mem_we_o  out  1 each  backing-memory request and write strobe.
REQ-012 mem_addr_o, mem_wdata_o  out  32 each  backing-memory word address and write data.
REQ-013 mem_ack_i  in  1  one-cycle completion pulse from backing memory.
REQ-014 mem_rdata_i  in  32  read data, valid with mem_ack_i.
REQ-015 hit_cnt_o, miss_cnt_o  out  16 each  statistics counters (see Configuration).

Function
REQ-016 Address split SHALL be index = addr[IDXW+1:2], tag = addr[31:IDXW+2]; each line holds a valid bit, a tag and one data word.
REQ-017 The FSM SHALL have states IDLE, RMISS, WTHRU and RESP.
REQ-018 In IDLE, a read hit SHALL return line data combinationally on cpu_rdata_o with cpu_stall_o=0 (zero-cycle latency).
REQ-019 In IDLE, a read miss SHALL drive cpu_stall_o=1 combinationally and transition to RMISS.
REQ-020 In IDLE, any write SHALL drive cpu_stall_o=1 and transition to WTHRU; when cpu_rd_i and cpu_wr_i are both high, the access SHALL be treated as a write.
REQ-021 In RMISS and WTHRU, the block SHALL drive mem_req_o=1 with stable address/data until the mem_ack_i cycle, and SHALL hold cpu_stall_o=1.
REQ-022 On mem_ack_i in RMISS, the block SHALL write mem_rdata_i, the tag and valid=1 into the line, then transition to RESP.
REQ-023 On mem_ack_i in WTHRU, the block SHALL update the line data only if it is a hit (write-through, no write-allocate), then transition to RESP.
REQ-024 In RESP, the block SHALL drive cpu_stall_o=0 and cpu_rdata_o from the line, SHALL NOT re-process the held request, and SHALL return to IDLE.
REQ-025 The block SHALL ignore mem_ack_i in IDLE and RESP.
REQ-026 When no request is pending, mem_req_o, mem_we_o and cpu_stall_o SHALL be 0.

Reset
REQ-027 With rst_i high at a clock edge, the block SHALL enter IDLE and clear all valid bits, mem_req_o and mem_we_o; outputs SHALL be 0 from the following cycle.
REQ-028 Reset during RMISS or WTHRU SHALL abandon the access and drop mem_req_o after the edge; a late mem_ack_i SHALL have no effect.
REQ-029 Line data and tag storage SHALL NOT require reset.

Configuration
REQ-030 With macro DCACHE_STATS_EN defined, hit_cnt_o SHALL count IDLE read hits and miss_cnt_o SHALL count RMISS entries; both SHALL be 16-bit, saturate at 0xFFFF, and clear on reset.
REQ-031 Without DCACHE_STATS_EN, hit_cnt_o and miss_cnt_o SHALL be constant 0 and no counter logic SHALL be built.

Verification
REQ-032 After reset, read 0x0000_0040 with memory word 0x1234_5678 and ack after 3 cycles -> stall for 5 cycles total, rdata 0x1234_5678 in RESP; an immediate re-read hits with stall 0.
REQ-033 Write 0xDEAD_BEEF to cached 0x40 -> mem_we_o=1 with addr 0x40, then a read of 0x40 hits and returns 0xDEAD_BEEF.
REQ-034 Write to uncached 0x80, then read 0x80 -> the read misses (no allocate).
REQ-035 Read 0x40, then read 0x440 (same index, LINES=16) -> miss; a following read of 0x40 misses again (eviction).
REQ-036 Assert rst_i mid-RMISS with ack one cycle later -> mem_req_o=0 and the line stays invalid; with DCACHE_STATS_EN, 70000 hits leave hit_cnt_o=0xFFFF.

Source files
------------

// File: rtl/data_cache_if.sv
// CPU-side and backing-memory bus bundle for data_cache.
// slave is the cache; master is the pipeline and memory side.
interface data_cache_if;
  logic        cpu_rd_i;
  logic        cpu_wr_i;
  logic [31:0] cpu_addr_i;
  logic [31:0] cpu_wdata_i;
  logic [31:0] cpu_rdata_o;
  logic        cpu_stall_o;
  logic        mem_req_o;
  logic        mem_we_o;
  logic [31:0] mem_addr_o;
  logic [31:0] mem_wdata_o;
  logic        mem_ack_i;
  logic [31:0] mem_rdata_i;

  modport slave (
    input  cpu_rd_i,
    input  cpu_wr_i,
    input  cpu_addr_i,
    input  cpu_wdata_i,
    output cpu_rdata_o,
    output cpu_stall_o,
    output mem_req_o,
    output mem_we_o,
    output mem_addr_o,
    output mem_wdata_o,
    input  mem_ack_i,
    input  mem_rdata_i
  );

  modport master (
    output cpu_rd_i,
    output cpu_wr_i,
    output cpu_addr_i,
    output cpu_wdata_i,
    input  cpu_rdata_o,
    input  cpu_stall_o,
    input  mem_req_o,
    input  mem_we_o,
    input  mem_addr_o,
    input  mem_wdata_o,
    output mem_ack_i,
    output mem_rdata_i
  );
endinterface

// File: rtl/data_cache.sv
// Direct-mapped one-word-line write-through data cache, no write-allocate.
// Define DCACHE_STATS_EN to build saturating hit/miss counters.
module data_cache #(
  parameter int LINES = 16,
  parameter int IDXW  = 4
) (
  input  logic        clk_i,
  input  logic        rst_i,
  data_cache_if.slave bus,
  output logic [15:0] hit_cnt_o,
  output logic [15:0] miss_cnt_o
);
  localparam int TAGW = 30 - IDXW;

  typedef enum logic [1:0] {
    IDLE,
    RMISS,
    WTHRU,
    RESP
  } state_e;

  state_e state_q, state_d;

  logic [LINES-1:0] valid_q;
  logic [TAGW-1:0]  tag_q  [LINES];
  logic [31:0]      data_q [LINES];

  logic [IDXW-1:0] idx;
  logic [TAGW-1:0] tag;
  logic            hit;
  logic            is_rd;
  logic            is_wr;
  logic            idle_hit;
  logic            mem_req;
  logic            mem_we;
  logic            stall;
  logic            unused_addr;

  assign idx      = bus.cpu_addr_i[IDXW+1:2];
  assign tag      = bus.cpu_addr_i[31:IDXW+2];
  assign hit      = valid_q[idx] && (tag_q[idx] == tag);
  assign is_wr    = bus.cpu_wr_i;
  assign is_rd    = bus.cpu_rd_i && !bus.cpu_wr_i;
  assign idle_hit = (state_q == IDLE) && is_rd && hit;

  assign unused_addr = ^bus.cpu_addr_i[1:0];

  always_comb begin
    state_d = state_q;
    stall   = 1'b0;
    mem_req = 1'b0;
    mem_we  = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (is_wr) begin
          stall   = 1'b1;
          state_d = WTHRU;
        end else if (is_rd && !hit) begin
          stall   = 1'b1;
          state_d = RMISS;
        end
      end
      RMISS: begin
        stall   = 1'b1;
        mem_req = 1'b1;
        if (bus.mem_ack_i) state_d = RESP;
      end
      WTHRU: begin
        stall   = 1'b1;
        mem_req = 1'b1;
        mem_we  = 1'b1;
        if (bus.mem_ack_i) state_d = RESP;
      end
      RESP: begin
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  assign bus.cpu_stall_o = stall;
  assign bus.mem_req_o   = mem_req;
  assign bus.mem_we_o    = mem_we;
  assign bus.mem_addr_o  = mem_req
                         ? {bus.cpu_addr_i[31:2], 2'b00}
                         : 32'd0;
  assign bus.mem_wdata_o = mem_we ? bus.cpu_wdata_i : 32'd0;
  assign bus.cpu_rdata_o = (idle_hit || state_q == RESP)
                         ? data_q[idx]
                         : 32'd0;

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q <= IDLE;
      valid_q <= '0;
    end else begin
      state_q <= state_d;
      if (state_q == RMISS && bus.mem_ack_i)
        valid_q[idx] <= 1'b1;
    end
  end

  // Payload storage needs no reset; validity lives in valid_q.
  always_ff @(posedge clk_i) begin
    if (!rst_i && bus.mem_ack_i) begin
      if (state_q == RMISS) begin
        data_q[idx] <= bus.mem_rdata_i;
        tag_q[idx]  <= tag;
      end else if (state_q == WTHRU && hit) begin
        data_q[idx] <= bus.cpu_wdata_i;
      end
    end
  end

`ifdef DCACHE_STATS_EN
  logic [15:0] hit_cnt_q;
  logic [15:0] miss_cnt_q;

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      hit_cnt_q  <= 16'd0;
      miss_cnt_q <= 16'd0;
    end else begin
      if (idle_hit && hit_cnt_q != 16'hFFFF)
        hit_cnt_q <= hit_cnt_q + 16'd1;
      if (state_q == IDLE && state_d == RMISS
          && miss_cnt_q != 16'hFFFF)
        miss_cnt_q <= miss_cnt_q + 16'd1;
    end
  end

  assign hit_cnt_o  = hit_cnt_q;
  assign miss_cnt_o = miss_cnt_q;
`else
  assign hit_cnt_o  = 16'd0;
  assign miss_cnt_o = 16'd0;
`endif
endmodule

// File: tb/tb_data_cache.sv
// Directed bench for data_cache with a latency-3 backing memory model.
// Build with DCACHE_STATS_EN to also exercise counter saturation.
module tb_data_cache;
  logic        clk;
  logic        rst;
  logic [15:0] hit_cnt;
  logic [15:0] miss_cnt;

  data_cache_if bus ();

  data_cache #(
    .LINES(16),
    .IDXW (4)
  ) dut (
    .clk_i     (clk),
    .rst_i     (rst),
    .bus       (bus),
    .hit_cnt_o (hit_cnt),
    .miss_cnt_o(miss_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check(input string tag,
                       input logic [31:0] got,
                       input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  logic [31:0] mem [logic [31:0]];
  bit ack_en   = 1'b1;
  bit late_ack = 1'b0;
  int ack_cnt  = 0;

  // Memory answers on the 4th cycle of a request (3 wait cycles).
  initial begin
    bus.mem_ack_i   = 1'b0;
    bus.mem_rdata_i = 32'd0;
    forever begin
      @(negedge clk);
      bus.mem_ack_i = 1'b0;
      if (bus.mem_req_o && ack_en) begin
        if (ack_cnt == 3) begin
          ack_cnt = 0;
          bus.mem_ack_i = 1'b1;
          if (bus.mem_we_o)
            mem[bus.mem_addr_o] = bus.mem_wdata_o;
          bus.mem_rdata_i = mem.exists(bus.mem_addr_o)
                          ? mem[bus.mem_addr_o] : 32'd0;
        end else begin
          ack_cnt++;
        end
      end else begin
        ack_cnt = 0;
      end
      if (late_ack) bus.mem_ack_i = 1'b1;
    end
  end

  // Called at posedge+1; returns at posedge+1 with the bus idle.
  task automatic access(input bit rd, input bit wr,
                        input logic [31:0] addr,
                        input logic [31:0] wdata,
                        output int n_stall,
                        output logic [31:0] rdata,
                        output bit saw_we,
                        output logic [31:0] we_addr);
    n_stall = 0;
    saw_we  = 1'b0;
    we_addr = 32'd0;
    rdata   = 32'd0;
    bus.cpu_rd_i    = rd;
    bus.cpu_wr_i    = wr;
    bus.cpu_addr_i  = addr;
    bus.cpu_wdata_i = wdata;
    for (int c = 0; c < 40; c++) begin
      #2;
      if (!bus.cpu_stall_o) break;
      n_stall++;
      if (bus.mem_we_o) begin
        saw_we  = 1'b1;
        we_addr = bus.mem_addr_o;
      end
      @(posedge clk);
      #1;
    end
    if (bus.cpu_stall_o) check("timeout", 32'd1, 32'd0);
    rdata = bus.cpu_rdata_o;
    @(posedge clk);
    #1;
    bus.cpu_rd_i = 1'b0;
    bus.cpu_wr_i = 1'b0;
  endtask

  int          ns;
  logic [31:0] rd_v;
  bit          we_v;
  logic [31:0] wa_v;

  initial begin
    mem[32'h40]  = 32'h1234_5678;
    mem[32'h440] = 32'hCAFE_F00D;
    rst = 1'b1;
    bus.cpu_rd_i    = 1'b0;
    bus.cpu_wr_i    = 1'b0;
    bus.cpu_addr_i  = 32'd0;
    bus.cpu_wdata_i = 32'd0;
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
    #2;
    check("rst_stall", {31'd0, bus.cpu_stall_o}, 32'd0);
    check("rst_req", {31'd0, bus.mem_req_o}, 32'd0);
    check("rst_we", {31'd0, bus.mem_we_o}, 32'd0);
    check("rst_rdata", bus.cpu_rdata_o, 32'd0);
    check("rst_hits", {16'd0, hit_cnt}, 32'd0);
    check("rst_miss", {16'd0, miss_cnt}, 32'd0);
    @(posedge clk);
    #1;

    access(1, 0, 32'h40, 32'd0, ns, rd_v, we_v, wa_v);
    check("miss40_stall", ns, 5);
    check("miss40_data", rd_v, 32'h1234_5678);
    access(1, 0, 32'h40, 32'd0, ns, rd_v, we_v, wa_v);
    check("hit40_stall", ns, 0);
    check("hit40_data", rd_v, 32'h1234_5678);

    access(0, 1, 32'h40, 32'hDEAD_BEEF, ns, rd_v, we_v, wa_v);
    check("wr40_stall", ns, 5);
    check("wr40_we", {31'd0, we_v}, 32'd1);
    check("wr40_addr", wa_v, 32'h40);
    access(1, 0, 32'h40, 32'd0, ns, rd_v, we_v, wa_v);
    check("rdwr40_stall", ns, 0);
    check("rdwr40_data", rd_v, 32'hDEAD_BEEF);

    access(0, 1, 32'h80, 32'h1111_2222, ns, rd_v, we_v, wa_v);
    check("wr80_addr", wa_v, 32'h80);
    access(1, 0, 32'h80, 32'd0, ns, rd_v, we_v, wa_v);
    check("noalloc80_stall", ns, 5);
    check("noalloc80_data", rd_v, 32'h1111_2222);

    access(1, 0, 32'h440, 32'd0, ns, rd_v, we_v, wa_v);
    check("evict440_stall", ns, 5);
    check("evict440_data", rd_v, 32'hCAFE_F00D);
    access(1, 0, 32'h40, 32'd0, ns, rd_v, we_v, wa_v);
    check("reload40_stall", ns, 5);
    check("reload40_data", rd_v, 32'hDEAD_BEEF);

    // Stray ack while idle must not start or alter anything.
    late_ack = 1'b1;
    @(posedge clk);
    #1;
    late_ack = 1'b0;
    #2;
    check("idle_ack_req", {31'd0, bus.mem_req_o}, 32'd0);
    check("idle_ack_stall", {31'd0, bus.cpu_stall_o}, 32'd0);
    @(posedge clk);
    #1;
    access(1, 0, 32'h40, 32'd0, ns, rd_v, we_v, wa_v);
    check("idle_ack_hit", ns, 0);
    check("idle_ack_data", rd_v, 32'hDEAD_BEEF);

    access(1, 1, 32'h40, 32'h5555_AAAA, ns, rd_v, we_v, wa_v);
    check("both_we", {31'd0, we_v}, 32'd1);
    check("both_stall", ns, 5);
    access(1, 0, 32'h40, 32'd0, ns, rd_v, we_v, wa_v);
    check("both_hit", ns, 0);
    check("both_data", rd_v, 32'h5555_AAAA);

    // Reset in the middle of a read miss, ack arrives late.
    ack_en = 1'b0;
    bus.cpu_rd_i   = 1'b1;
    bus.cpu_addr_i = 32'h840;
    repeat (3) @(posedge clk);
    #1;
    #2;
    check("rmiss_req", {31'd0, bus.mem_req_o}, 32'd1);
    #1;
    rst = 1'b1;
    bus.cpu_rd_i = 1'b0;
    @(posedge clk);
    #1;
    rst = 1'b0;
    late_ack = 1'b1;
    #2;
    check("abort_req", {31'd0, bus.mem_req_o}, 32'd0);
    check("abort_stall", {31'd0, bus.cpu_stall_o}, 32'd0);
    @(posedge clk);
    #1;
    late_ack = 1'b0;
    ack_en = 1'b1;
    #2;
    check("late_ack_req", {31'd0, bus.mem_req_o}, 32'd0);
    @(posedge clk);
    #1;
    access(1, 0, 32'h840, 32'd0, ns, rd_v, we_v, wa_v);
    check("abort_line_stall", ns, 5);
    check("abort_line_data", rd_v, 32'd0);
    access(1, 0, 32'h40, 32'd0, ns, rd_v, we_v, wa_v);
    check("post_rst_stall", ns, 5);
    check("post_rst_data", rd_v, 32'h5555_AAAA);

`ifdef DCACHE_STATS_EN
    check("stats_hits0", {16'd0, hit_cnt}, 32'd0);
    check("stats_miss2", {16'd0, miss_cnt}, 32'd2);
    bus.cpu_rd_i   = 1'b1;
    bus.cpu_addr_i = 32'h40;
    repeat (70000) @(posedge clk);
    #1;
    bus.cpu_rd_i = 1'b0;
    #2;
    check("stats_sat", {16'd0, hit_cnt}, 32'h0000_FFFF);
`else
    check("stats_off_hit", {16'd0, hit_cnt}, 32'd0);
    check("stats_off_miss", {16'd0, miss_cnt}, 32'd0);
`endif

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end
endmodule
